// File: rtl/regfile_op_sequencer.sv
// Register-file operation sequencer: IDLE -> READ -> EXEC -> WRITE, one op in flight.
// Optional MAC (opcode 5) multiplier is built only when RFSEQ_MAC_EN is defined.
module regfile_op_sequencer #(
   parameter int M = 4,
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic [2:0]   req_op,
   input  logic [M-1:0] req_dst,
   input  logic [M-1:0] req_src1,
   input  logic [M-1:0] req_src2,
   input  logic [M-1:0] req_src3,
   output logic         done,
   output logic [W-1:0] result,
   output logic         err,
   output logic         zero,
   output logic         rf_read_en,
   output logic [M-1:0] rf_read_reg1,
   output logic [M-1:0] rf_read_reg2,
   output logic [M-1:0] rf_read_reg3,
   input  logic [W-1:0] rf_read_data1,
   input  logic [W-1:0] rf_read_data2,
   input  logic [W-1:0] rf_read_data3,
   output logic         rf_write_en,
   output logic [M-1:0] rf_write_reg,
   output logic [W-1:0] rf_write_data
);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WRITE} state_t;
   typedef enum logic [2:0] {
      OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_XOR, OP_MAC, OP_ADD3, OP_READ
   } op_t;

   state_t       state_q, state_d;
   op_t          op_q, op_d;
   logic [M-1:0] dst_q, dst_d;
   logic         req_ready_q, req_ready_d;
   logic         done_q, done_d;
   logic [W-1:0] result_q, result_d;
   logic         err_q, err_d;
   logic         zero_q, zero_d;
   logic         rd_en_q, rd_en_d;
   logic [M-1:0] rd_reg1_q, rd_reg1_d;
   logic [M-1:0] rd_reg2_q, rd_reg2_d;
   logic [M-1:0] rd_reg3_q, rd_reg3_d;
   logic         wr_en_q, wr_en_d;
   logic [M-1:0] wr_reg_q, wr_reg_d;
   logic [W-1:0] wr_data_q, wr_data_d;

   logic [W-1:0] alu_res;
   logic         alu_err;

   always_comb begin
      alu_res = '0;
      alu_err = 1'b0;
      unique case (op_q)
         OP_MOV:  alu_res = rf_read_data1;
         OP_ADD:  alu_res = rf_read_data1 + rf_read_data2;
         OP_SUB:  alu_res = rf_read_data1 - rf_read_data2;
         OP_AND:  alu_res = rf_read_data1 & rf_read_data2;
         OP_XOR:  alu_res = rf_read_data1 ^ rf_read_data2;
`ifdef RFSEQ_MAC_EN
         // Low W bits of the 2W-wide product equal the W-wide product.
         OP_MAC:  alu_res = (rf_read_data1 * rf_read_data2) + rf_read_data3;
`else
         OP_MAC:  begin
            alu_res = '0;
            alu_err = 1'b1;
         end
`endif
         OP_ADD3: alu_res = rf_read_data1 + rf_read_data2 + rf_read_data3;
         OP_READ: alu_res = rf_read_data1;
         default: alu_res = '0;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      dst_d       = dst_q;
      req_ready_d = req_ready_q;
      done_d      = done_q;
      result_d    = result_q;
      err_d       = err_q;
      zero_d      = zero_q;
      rd_en_d     = rd_en_q;
      rd_reg1_d   = rd_reg1_q;
      rd_reg2_d   = rd_reg2_q;
      rd_reg3_d   = rd_reg3_q;
      wr_en_d     = wr_en_q;
      wr_reg_d    = wr_reg_q;
      wr_data_d   = wr_data_q;
      unique case (state_q)
         S_IDLE: begin
            if (req_valid && req_ready_q) begin
               op_d        = op_t'(req_op);
               dst_d       = req_dst;
               rd_reg1_d   = req_src1;
               rd_reg2_d   = req_src2;
               rd_reg3_d   = req_src3;
               rd_en_d     = 1'b1;
               req_ready_d = 1'b0;
               state_d     = S_READ;
            end
         end
         S_READ: begin
            rd_en_d = 1'b0;
            state_d = S_EXEC;
         end
         S_EXEC: begin
            // Outputs are registered, so WRITE-cycle signals are loaded here.
            result_d  = alu_res;
            err_d     = alu_err;
            zero_d    = (alu_res == '0);
            done_d    = 1'b1;
            wr_en_d   = !alu_err && (op_q != OP_READ);
            wr_reg_d  = dst_q;
            wr_data_d = alu_res;
            state_d   = S_WRITE;
         end
         S_WRITE: begin
            done_d      = 1'b0;
            wr_en_d     = 1'b0;
            req_ready_d = 1'b1;
            state_d     = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         op_q        <= OP_MOV;
         dst_q       <= '0;
         req_ready_q <= 1'b1;
         done_q      <= 1'b0;
         result_q    <= '0;
         err_q       <= 1'b0;
         zero_q      <= 1'b0;
         rd_en_q     <= 1'b0;
         rd_reg1_q   <= '0;
         rd_reg2_q   <= '0;
         rd_reg3_q   <= '0;
         wr_en_q     <= 1'b0;
         wr_reg_q    <= '0;
         wr_data_q   <= '0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         dst_q       <= dst_d;
         req_ready_q <= req_ready_d;
         done_q      <= done_d;
         result_q    <= result_d;
         err_q       <= err_d;
         zero_q      <= zero_d;
         rd_en_q     <= rd_en_d;
         rd_reg1_q   <= rd_reg1_d;
         rd_reg2_q   <= rd_reg2_d;
         rd_reg3_q   <= rd_reg3_d;
         wr_en_q     <= wr_en_d;
         wr_reg_q    <= wr_reg_d;
         wr_data_q   <= wr_data_d;
      end
   end

   assign req_ready     = req_ready_q;
   assign done          = done_q;
   assign result        = result_q;
   assign err           = err_q;
   assign zero          = zero_q;
   assign rf_read_en    = rd_en_q;
   assign rf_read_reg1  = rd_reg1_q;
   assign rf_read_reg2  = rd_reg2_q;
   assign rf_read_reg3  = rd_reg3_q;
   assign rf_write_en   = wr_en_q;
   assign rf_write_reg  = wr_reg_q;
   assign rf_write_data = wr_data_q;

endmodule

// File: tb/tb_regfile_op_sequencer.sv
// Scoreboard bench for regfile_op_sequencer with a registered-read register file model.
module tb_regfile_op_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic [2:0] req_op = '0;
   logic [3:0] req_dst = '0, req_src1 = '0, req_src2 = '0, req_src3 = '0;
   logic       done;
   logic [7:0] result;
   logic       err, zero;
   logic       rf_read_en;
   logic [3:0] rf_read_reg1, rf_read_reg2, rf_read_reg3;
   logic [7:0] rf_read_data1, rf_read_data2, rf_read_data3;
   logic       rf_write_en;
   logic [3:0] rf_write_reg;
   logic [7:0] rf_write_data;

   regfile_op_sequencer #(.M(4), .W(8)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_dst(req_dst), .req_src1(req_src1), .req_src2(req_src2), .req_src3(req_src3),
      .done(done), .result(result), .err(err), .zero(zero),
      .rf_read_en(rf_read_en), .rf_read_reg1(rf_read_reg1), .rf_read_reg2(rf_read_reg2),
      .rf_read_reg3(rf_read_reg3), .rf_read_data1(rf_read_data1),
      .rf_read_data2(rf_read_data2), .rf_read_data3(rf_read_data3),
      .rf_write_en(rf_write_en), .rf_write_reg(rf_write_reg), .rf_write_data(rf_write_data)
   );

   always #5 clk = ~clk;

   logic [7:0] mem [16];

   always @(posedge clk) begin
      if (rf_read_en) begin
         rf_read_data1 <= mem[rf_read_reg1];
         rf_read_data2 <= mem[rf_read_reg2];
         rf_read_data3 <= mem[rf_read_reg3];
      end
      if (rf_write_en) mem[rf_write_reg] <= rf_write_data;
   end

   typedef struct {
      logic [7:0] res;
      logic       err;
      logic       zero;
      logic       wen;
      logic [3:0] wreg;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad = 0;
   logic wr_watch = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, expv);
      end
   endtask

   task automatic push(input logic [7:0] res, input logic e, input logic wen, input logic [3:0] wreg);
      exp_t x;
      x.res = res; x.err = e; x.zero = (res == 8'h00); x.wen = wen; x.wreg = wreg;
      sb.push_back(x);
   endtask

   // Monitor: compares every done pulse against the oldest expectation.
   always @(negedge clk) begin
      if (!rst) begin
         if (rf_read_en && rf_write_en) chk("rd_wr_overlap", 1, 0);
         if (done) begin
            if (sb.size() == 0) begin
               chk("unexpected_done", 1, 0);
            end else begin
               exp_t x;
               x = sb.pop_front();
               chk("result", result, x.res);
               chk("err", err, x.err);
               chk("zero", zero, x.zero);
               chk("write_en", rf_write_en, x.wen);
               if (x.wen) begin
                  chk("write_reg", rf_write_reg, x.wreg);
                  chk("write_data", rf_write_data, x.res);
               end
            end
         end
      end
      if (wr_watch && rf_write_en) chk("write_during_abort", 1, 0);
   end

   task automatic run_op(input logic [2:0] op, input logic [3:0] dst, input logic [3:0] s1,
                         input logic [3:0] s2, input logic [3:0] s3,
                         input logic [7:0] res, input logic e, input logic wen);
      logic [7:0] old;
      int n, rd_cnt;
      old = mem[dst];
      @(negedge clk);
      chk("ready_before", req_ready, 1);
      push(res, e, wen, dst);
      req_valid = 1'b1; req_op = op; req_dst = dst;
      req_src1 = s1; req_src2 = s2; req_src3 = s3;
      @(posedge clk); #1;
      req_valid = 1'b0;
      n = 0; rd_cnt = 0;
      do begin
         @(negedge clk);
         n++;
         if (rf_read_en) rd_cnt++;
      end while (!done && n < 10);
      chk("latency", n, 3);
      chk("read_en_cycles", rd_cnt, 1);
      @(negedge clk);
      chk("ready_after", req_ready, 1);
      chk("mem_dst", mem[dst], wen ? res : old);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 8'h00;
      mem[1] = 8'h12; mem[11] = 8'h34; mem[4] = 8'h77; mem[5] = 8'h10;
      mem[6] = 8'h20; mem[7] = 8'h5A; mem[8] = 8'h11; mem[9] = 8'hC3;
      mem[10] = 8'h05; mem[14] = 8'hEE; mem[15] = 8'h99;

      repeat (2) @(negedge clk);
      chk("rst_ready", req_ready, 1);
      chk("rst_outs", {done, err, zero, rf_read_en, rf_write_en}, 0);
      chk("rst_data", {result, rf_write_data, rf_write_reg, rf_read_reg1, rf_read_reg2, rf_read_reg3}, 0);
      rst = 1'b0;

      // ADD r3 = r1 + r11
      run_op(3'd1, 4'd3, 4'd1, 4'd11, 4'd0, 8'h46, 1'b0, 1'b1);
      // SUB wrap: 0x10 - 0x20
      run_op(3'd2, 4'd12, 4'd5, 4'd6, 4'd0, 8'hF0, 1'b0, 1'b1);
      // XOR same source -> zero
      run_op(3'd4, 4'd13, 4'd4, 4'd4, 4'd0, 8'h00, 1'b0, 1'b1);
`ifdef RFSEQ_MAC_EN
      run_op(3'd5, 4'd14, 4'd5, 4'd8, 4'd10, 8'h15, 1'b0, 1'b1);
`else
      run_op(3'd5, 4'd14, 4'd5, 4'd8, 4'd10, 8'h00, 1'b1, 1'b0);
`endif
      // ADD3 and AND
      run_op(3'd6, 4'd0, 4'd1, 4'd11, 4'd10, 8'h4B, 1'b0, 1'b1);
      run_op(3'd3, 4'd2, 4'd4, 4'd6, 4'd0, 8'h20, 1'b0, 1'b1);

      // Reset during EXEC of an ADD into r15: no write, outputs back to reset
      @(negedge clk);
      req_valid = 1'b1; req_op = 3'd1; req_dst = 4'd15; req_src1 = 4'd1; req_src2 = 4'd11;
      @(posedge clk); #1;
      req_valid = 1'b0;
      wr_watch = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("abort_outs", {done, err, zero, rf_read_en, rf_write_en}, 0);
      chk("abort_ready", req_ready, 1);
      @(negedge clk);
      chk("abort_data", {result, rf_write_data, rf_write_reg, rf_read_reg1, rf_read_reg2, rf_read_reg3}, 0);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      chk("abort_ready_after", req_ready, 1);
      chk("abort_no_done", done, 0);
      chk("abort_mem", mem[15], 8'h99);
      wr_watch = 1'b0;

      // MOV r2 <- r7
      run_op(3'd0, 4'd2, 4'd7, 4'd0, 4'd0, 8'h5A, 1'b0, 1'b1);

      // READ r9 with req_valid held: busy requests are ignored, re-accepted after done
      @(negedge clk);
      push(8'hC3, 1'b0, 1'b0, 4'd0);
      push(8'hC3, 1'b0, 1'b0, 4'd0);
      req_valid = 1'b1; req_op = 3'd7; req_dst = 4'd0; req_src1 = 4'd9;
      req_src2 = 4'd0; req_src3 = 4'd0;
      @(posedge clk);
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         chk("busy_ready_low", req_ready, 0);
         chk("busy_read_en", rf_read_en, (k == 1) ? 1 : 0);
      end
      @(negedge clk);
      chk("held_ready_high", req_ready, 1);
      chk("held_not_yet", rf_read_en, 0);
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      chk("held_reaccept", rf_read_en, 1);
      chk("read_no_write_mem0", mem[0], 8'h4B);

      for (int t = 0; t < 20 && sb.size() != 0; t++) @(negedge clk);
      chk("scoreboard_empty", sb.size(), 0);
      repeat (2) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
